// File: rtl/wall_collision_checker.sv
// wall_collision_checker
// Answers whether a sprite may take one step in a given direction without
// overlapping any wall rectangle or leaving the playfield. The wall table is
// read from an external ROM one rectangle per cycle; requests and responses
// use valid/ready handshakes and only one query is in flight at a time.
module wall_collision_checker #(
  parameter int NUM_RECTS = 54,
  parameter int HALF      = 10,
  parameter int STEP      = 1,
  parameter int FIELD_W   = 381,
  parameter int FIELD_H   = 433
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [9:0] req_x,
  input  logic [9:0] req_y,
  input  logic [1:0] req_dir,
  output logic [5:0] rom_addr,
  output logic       rom_en,
  input  logic [9:0] rom_xmin,
  input  logic [9:0] rom_ymin,
  input  logic [9:0] rom_xmax,
  input  logic [9:0] rom_ymax,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_blocked,
  output logic [5:0] rsp_wall_idx
);

  // Box coordinates are signed so a step past the left/top edge shows up as
  // a negative value; 12 bits leave headroom for a 10-bit centre plus the
  // step and half-size without wrapping.
  localparam int CW = 12;
  typedef logic signed [CW-1:0] coord_t;

  localparam coord_t     STEP_C   = coord_t'(STEP);
  localparam coord_t     HALF_C   = coord_t'(HALF);
  localparam coord_t     XMAX_C   = coord_t'(FIELD_W - 1);
  localparam coord_t     YMAX_C   = coord_t'(FIELD_H - 1);
  localparam coord_t     ZERO_C   = '0;
  localparam logic [5:0] LAST_IDX = 6'(NUM_RECTS - 1);
  localparam logic [5:0] OOB_IDX  = 6'd63;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_SCAN,
    S_RESP
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic [1:0] dir_q, dir_d;
  coord_t     cxmin_q, cxmin_d;
  coord_t     cxmax_q, cxmax_d;
  coord_t     cymin_q, cymin_d;
  coord_t     cymax_q, cymax_d;
  logic [5:0] addr_q, addr_d;
  logic       issue_done_q, issue_done_d;
  logic       cmp_valid_q, cmp_valid_d;
  logic [5:0] cmp_idx_q, cmp_idx_d;
  logic       blocked_q, blocked_d;
  logic [5:0] wall_idx_q, wall_idx_d;

  coord_t cx, cy;
  coord_t bxmin, bxmax, bymin, bymax;
  coord_t rxmin, rxmax, rymin, rymax;
  logic   oob;
  logic   hit;
  logic   issue;

  // Candidate box for the latched query: move the centre one step, then
  // extend by the half-size on each side and test against the field edges.
  always_comb begin
    cx = coord_t'({2'b00, x_q});
    cy = coord_t'({2'b00, y_q});
    case (dir_q)
      2'd0:    cy = cy - STEP_C;
      2'd1:    cy = cy + STEP_C;
      2'd2:    cx = cx - STEP_C;
      default: cx = cx + STEP_C;
    endcase
    bxmin = cx - HALF_C;
    bxmax = cx + HALF_C;
    bymin = cy - HALF_C;
    bymax = cy + HALF_C;
    oob   = (bxmin < ZERO_C) || (bymin < ZERO_C) ||
            (bxmax > XMAX_C) || (bymax > YMAX_C);
  end

  // Inclusive overlap test between the stored box and the rectangle the ROM
  // is presenting this cycle.
  always_comb begin
    rxmin = coord_t'({2'b00, rom_xmin});
    rxmax = coord_t'({2'b00, rom_xmax});
    rymin = coord_t'({2'b00, rom_ymin});
    rymax = coord_t'({2'b00, rom_ymax});
    hit   = (cxmin_q <= rxmax) && (cxmax_q >= rxmin) &&
            (cymin_q <= rymax) && (cymax_q >= rymin);
  end

  // Next-state logic: accept, compute box, scan the table with a one-cycle
  // read pipeline, then hold the result until the consumer takes it.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    cxmin_d      = cxmin_q;
    cxmax_d      = cxmax_q;
    cymin_d      = cymin_q;
    cymax_d      = cymax_q;
    addr_d       = addr_q;
    issue_done_d = issue_done_q;
    cmp_valid_d  = cmp_valid_q;
    cmp_idx_d    = cmp_idx_q;
    blocked_d    = blocked_q;
    wall_idx_d   = wall_idx_q;
    issue        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          x_d     = req_x;
          y_d     = req_y;
          dir_d   = req_dir;
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        cxmin_d = bxmin;
        cxmax_d = bxmax;
        cymin_d = bymin;
        cymax_d = bymax;
        if (oob) begin
          blocked_d  = 1'b1;
          wall_idx_d = OOB_IDX;
          state_d    = S_RESP;
        end else begin
          addr_d       = '0;
          issue_done_d = 1'b0;
          cmp_valid_d  = 1'b0;
          state_d      = S_SCAN;
        end
      end

      S_SCAN: begin
        issue       = !issue_done_q;
        cmp_valid_d = issue;
        cmp_idx_d   = addr_q;
        if (cmp_valid_q && hit) begin
          blocked_d  = 1'b1;
          wall_idx_d = cmp_idx_q;
          state_d    = S_RESP;
        end else if (cmp_valid_q && (cmp_idx_q == LAST_IDX)) begin
          blocked_d  = 1'b0;
          wall_idx_d = '0;
          state_d    = S_RESP;
        end else if (issue) begin
          if (addr_q == LAST_IDX) begin
            issue_done_d = 1'b1;
          end else begin
            addr_d = addr_q + 6'd1;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      dir_q        <= '0;
      cxmin_q      <= '0;
      cxmax_q      <= '0;
      cymin_q      <= '0;
      cymax_q      <= '0;
      addr_q       <= '0;
      issue_done_q <= 1'b0;
      cmp_valid_q  <= 1'b0;
      cmp_idx_q    <= '0;
      blocked_q    <= 1'b0;
      wall_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
      cxmin_q      <= cxmin_d;
      cxmax_q      <= cxmax_d;
      cymin_q      <= cymin_d;
      cymax_q      <= cymax_d;
      addr_q       <= addr_d;
      issue_done_q <= issue_done_d;
      cmp_valid_q  <= cmp_valid_d;
      cmp_idx_q    <= cmp_idx_d;
      blocked_q    <= blocked_d;
      wall_idx_q   <= wall_idx_d;
    end
  end

  // Handshake and ROM strobes follow directly from the state register.
  always_comb begin
    req_ready    = (state_q == S_IDLE);
    rsp_valid    = (state_q == S_RESP);
    rom_en       = issue;
    rom_addr     = addr_q;
    rsp_blocked  = blocked_q;
    rsp_wall_idx = wall_idx_q;
  end

endmodule

// File: tb/tb_wall_collision_checker.sv
// tb_wall_collision_checker
// Drives directed and random queries, predicts each result with a simple
// geometric model and checks responses from a separate monitor process.
module tb_wall_collision_checker;

  localparam int N = 3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [9:0] req_x = '0;
  logic [9:0] req_y = '0;
  logic [1:0] req_dir = '0;
  logic [5:0] rom_addr;
  logic       rom_en;
  logic [9:0] rom_xmin = '0;
  logic [9:0] rom_ymin = '0;
  logic [9:0] rom_xmax = '0;
  logic [9:0] rom_ymax = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_blocked;
  logic [5:0] rsp_wall_idx;

  wall_collision_checker #(
    .NUM_RECTS(N), .HALF(10), .STEP(1), .FIELD_W(381), .FIELD_H(433)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_dir(req_dir),
    .rom_addr(rom_addr), .rom_en(rom_en),
    .rom_xmin(rom_xmin), .rom_ymin(rom_ymin),
    .rom_xmax(rom_xmax), .rom_ymax(rom_ymax),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_blocked(rsp_blocked), .rsp_wall_idx(rsp_wall_idx)
  );

  always #5 clk = ~clk;

  int rect_tab [N][4] = '{'{0, 0, 380, 8}, '{184, 36, 196, 128}, '{372, 0, 380, 432}};

  // Synchronous ROM: data for an address appears the cycle after rom_en.
  always @(posedge clk) begin
    int a;
    a = int'(rom_addr);
    if (rom_en && a < N) begin
      rom_xmin <= 10'(rect_tab[a][0]);
      rom_ymin <= 10'(rect_tab[a][1]);
      rom_xmax <= 10'(rect_tab[a][2]);
      rom_ymax <= 10'(rect_tab[a][3]);
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int blocked;
    int idx;
    int lat;
    int roms;
    int acc;
  } exp_t;

  exp_t expq[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail = 0;
  int   stall_req = 0;
  int   stall_left = 0;
  int   in_resp = 0;
  int   hs_pending = 0;
  int   rom_total = 0;
  int   rom_mark = 0;
  int   held_b = 0;
  int   held_i = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: geometric answer straight from the movement rules.
  function automatic exp_t model(input int x, input int y, input int d);
    exp_t r;
    int cx, cy, xmin, xmax, ymin, ymax;
    cx = x;
    cy = y;
    if (d == 0) cy = cy - 1;
    else if (d == 1) cy = cy + 1;
    else if (d == 2) cx = cx - 1;
    else cx = cx + 1;
    xmin = cx - 10; xmax = cx + 10; ymin = cy - 10; ymax = cy + 10;
    r.acc = 0;
    if (xmin < 0 || ymin < 0 || xmax > 380 || ymax > 432) begin
      r.blocked = 1; r.idx = 63; r.lat = 2; r.roms = 0;
      return r;
    end
    for (int k = 0; k < N; k++) begin
      if (xmin <= rect_tab[k][2] && xmax >= rect_tab[k][0] &&
          ymin <= rect_tab[k][3] && ymax >= rect_tab[k][1]) begin
        r.blocked = 1; r.idx = k; r.lat = 4 + k;
        r.roms = (k + 2 < N) ? k + 2 : N;
        return r;
      end
    end
    r.blocked = 0; r.idx = 0; r.lat = 3 + N; r.roms = N;
    return r;
  endfunction

  // Present one query, push its predicted response when it is accepted, then
  // scramble the request inputs to show they are not re-read.
  task automatic applyStimulus(input int x, input int y, input int d);
    int g;
    exp_t e;
    g = 0;
    @(negedge clk);
    while (!req_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (g >= 300) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL req_ready_timeout: got 0, expected 1");
      return;
    end
    req_x = 10'(x);
    req_y = 10'(y);
    req_dir = 2'(d);
    req_valid = 1'b1;
    e = model(x, y, d);
    e.acc = cyc;
    expq.push_back(e);
    @(negedge clk);
    req_valid = 1'b0;
    req_x = 10'($urandom);
    req_y = 10'($urandom);
    req_dir = 2'($urandom);
  endtask

  task automatic waitDone();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while ((expq.size() != 0 || rsp_valid || in_resp != 0) && g < 300);
    if (g >= 300) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL response_timeout: pending %0d, expected 0", expq.size());
      expq.delete();
    end
  endtask

  // Monitor: counts ROM strobes, pops the scoreboard on each new response,
  // applies back-pressure and checks stability and handshake behaviour.
  always @(negedge clk) begin
    if (!reset_n) begin
      expq.delete();
      in_resp = 0;
      hs_pending = 0;
      rom_mark = rom_total;
      rsp_ready = 1'b1;
    end else begin
      if (rom_en) rom_total++;
      if (hs_pending != 0) begin
        hs_pending = 0;
        in_resp = 0;
        checkOutput("rsp_valid_after_hs", int'(rsp_valid), 0);
        checkOutput("req_ready_after_hs", int'(req_ready), 1);
      end
      if (rsp_valid && in_resp == 0) begin
        in_resp = 1;
        if (expq.size() == 0) begin
          checkOutput("unexpected_rsp", 1, 0);
        end else begin
          cur = expq.pop_front();
          checkOutput("rsp_blocked", int'(rsp_blocked), cur.blocked);
          checkOutput("rsp_wall_idx", int'(rsp_wall_idx), cur.idx);
          checkOutput("latency", cyc - cur.acc, cur.lat);
          checkOutput("rom_en_cycles", rom_total - rom_mark, cur.roms);
          if (cur.roms > 0) checkOutput("rom_addr_last", int'(rom_addr), cur.roms - 1);
        end
        held_b = int'(rsp_blocked);
        held_i = int'(rsp_wall_idx);
        stall_left = stall_req;
        rom_mark = rom_total;
      end else if (rsp_valid) begin
        checkOutput("rsp_blocked_stable", int'(rsp_blocked), held_b);
        checkOutput("rsp_wall_idx_stable", int'(rsp_wall_idx), held_i);
      end
      if (rsp_valid) begin
        checkOutput("req_ready_busy", int'(req_ready), 0);
        if (stall_left > 0) begin
          rsp_ready = 1'b0;
          stall_left--;
        end else begin
          rsp_ready = 1'b1;
          hs_pending = 1;
        end
      end
    end
  end

  // Test sequence: reset state, directed cases, back-pressure, mid-scan
  // reset, then random queries across the field.
  initial begin
    repeat (3) @(negedge clk);
    checkOutput("reset_req_ready", int'(req_ready), 1);
    checkOutput("reset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("reset_rsp_blocked", int'(rsp_blocked), 0);
    checkOutput("reset_rsp_wall_idx", int'(rsp_wall_idx), 0);
    checkOutput("reset_rom_en", int'(rom_en), 0);
    checkOutput("reset_rom_addr", int'(rom_addr), 0);
    reset_n = 1'b1;

    applyStimulus(190, 20, 0);  waitDone();
    applyStimulus(190, 19, 0);  waitDone();
    applyStimulus(190, 25, 1);  waitDone();
    applyStimulus(10, 100, 2);  waitDone();

    stall_req = 5;
    applyStimulus(190, 20, 0);  waitDone();
    stall_req = 0;

    applyStimulus(190, 20, 0);
    @(negedge clk);
    checkOutput("scan_rom_en", int'(rom_en), 1);
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("midreset_rsp_valid", int'(rsp_valid), 0);
    checkOutput("midreset_rom_en", int'(rom_en), 0);
    checkOutput("midreset_req_ready", int'(req_ready), 1);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(190, 25, 1);  waitDone();

    applyStimulus(370, 200, 3); waitDone();
    applyStimulus(10, 422, 1);  waitDone();
    applyStimulus(361, 300, 3); waitDone();

    for (int i = 0; i < 40; i++) begin
      stall_req = int'($urandom_range(0, 2));
      applyStimulus(int'($urandom_range(0, 380)), int'($urandom_range(0, 432)),
                    int'($urandom_range(0, 3)));
      waitDone();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
